// File: rtl/csr_trap_ctrl.sv
// ---------------------------------------------------------------------------
// csr_trap_ctrl
//
// Purpose:
//   Execute-stage controller for the machine-mode CSR file access port.
//   - CSRRW/CSRRS/CSRRC and their immediate forms run as one read cycle
//     followed by one write cycle.
//   - Exceptions are committed into mepc/mcause/mtval through cause_in,
//     epc_in and tval_in.
//   - MRET reads mepc and redirects the PC to it.
//   The pipeline is stalled while the controller is busy. Trap entry and
//   MRET each produce a one-cycle flush and a one-cycle PC redirect.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   csr_req, csr_funct3,     CSR instruction from EX (sampled in IDLE)
//   csr_req_addr,
//   csr_rs1_val, csr_rs1_idx
//   exc_req, exc_cause,      pending exception from EX (sampled in IDLE)
//   exc_pc, exc_tval
//   mret_req                 MRET in EX (sampled in IDLE)
//   csr_out, mtvec_out       CSR file read data and trap vector
//   csr_addr                 CSR file read address
//   csr_wr_addr,             CSR file write port (wr_csr_n is active-low)
//   csr_data_in, wr_csr_n
//   is_mret                  MRET strobe to the CSR file
//   cause_in, epc_in,        trap commit values to the CSR file
//   tval_in
//   csr_done, rd_data        old CSR value for write-back to rd
//   stall, flush,            pipeline control
//   redirect_valid,
//   redirect_pc
// ---------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter logic [11:0] MEPC_ADDR          = 12'h341,
    parameter logic [1:0]  NOT_EXCEPTION      = 2'b00,
    parameter logic [1:0]  I_ADDR_MISALIGNMENT = 2'b01,
    parameter logic [1:0]  ILLEGAL_IR         = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_req_addr,
    input  logic [31:0] csr_rs1_val,
    input  logic [4:0]  csr_rs1_idx,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic [31:0] csr_out,
    input  logic [31:0] mtvec_out,
    output logic [11:0] csr_addr,
    output logic [11:0] csr_wr_addr,
    output logic [31:0] csr_data_in,
    output logic        wr_csr_n,
    output logic        is_mret,
    output logic [1:0]  cause_in,
    output logic [31:0] epc_in,
    output logic [31:0] tval_in,
    output logic        csr_done,
    output logic [31:0] rd_data,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CSR_RD = 3'd1,
        CSR_WR = 3'd2,
        TRAP   = 3'd3,
        MRET   = 3'd4
    } state_t;

    state_t state, next_state;

    // Latched request context (data only, no reset needed).
    logic [1:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] opnd_q;
    logic        wr_en_q;
    logic [1:0]  cause_q;
    logic [31:0] pc_q;
    logic [31:0] tval_q;
    logic [31:0] old_q;

    // Visible while idle, so it is reset with the control state.
    logic [31:0] rd_q;

    logic ro_trap;

    // funct3[1:0]: 01 = write, 10 = set bits, 11 = clear bits.
    function automatic logic [31:0] csr_wdata(input logic [1:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] opnd);
        logic [31:0] res;
        case (op)
            2'b10:   res = old | opnd;
            2'b11:   res = old & ~opnd;
            default: res = opnd;
        endcase
        return res;
    endfunction

    // A write to the read-only CSR space (addr[11:10] == 2'b11) is illegal.
    assign ro_trap = wr_en_q && (addr_q[11:10] == 2'b11);

    // Control state and the held rd_data value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rd_q  <= 32'd0;
        end else begin
            state <= next_state;
            if (state == CSR_WR) begin
                rd_q <= old_q;
            end
        end
    end

    // Request capture in IDLE, CSR read capture in CSR_RD.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (exc_req) begin
                    cause_q <= exc_cause;
                    pc_q    <= exc_pc;
                    tval_q  <= exc_tval;
                end else if (!mret_req && csr_req) begin
                    op_q    <= csr_funct3[1:0];
                    addr_q  <= csr_req_addr;
                    pc_q    <= exc_pc;
                    opnd_q  <= csr_funct3[2] ? {27'd0, csr_rs1_idx} : csr_rs1_val;
                    // Set/clear with x0 or zimm=0 is a pure read.
                    wr_en_q <= (csr_funct3[1:0] == 2'b01) || (csr_rs1_idx != 5'd0);
                end
            end
            CSR_RD: begin
                old_q <= csr_out;
                if (ro_trap) begin
                    cause_q <= ILLEGAL_IR;
                    tval_q  <= 32'd0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state     = state;
        csr_addr       = 12'd0;
        csr_wr_addr    = 12'd0;
        csr_data_in    = 32'd0;
        wr_csr_n       = 1'b1;
        is_mret        = 1'b0;
        cause_in       = NOT_EXCEPTION;
        epc_in         = 32'd0;
        tval_in        = 32'd0;
        csr_done       = 1'b0;
        rd_data        = rd_q;
        stall          = (state != IDLE);
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        case (state)
            IDLE: begin
                if (exc_req) begin
                    next_state = TRAP;
                end else if (mret_req) begin
                    next_state = MRET;
                end else if (csr_req) begin
                    next_state = CSR_RD;
                end
            end
            CSR_RD: begin
                csr_addr   = addr_q;
                next_state = ro_trap ? TRAP : CSR_WR;
            end
            CSR_WR: begin
                wr_csr_n    = !wr_en_q;
                csr_wr_addr = addr_q;
                csr_data_in = csr_wdata(op_q, old_q, opnd_q);
                csr_done    = 1'b1;
                rd_data     = old_q;
                next_state  = IDLE;
            end
            TRAP: begin
                cause_in       = cause_q;
                epc_in         = pc_q;
                tval_in        = tval_q;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                // Direct mode only: mode bits of mtvec are ignored.
                redirect_pc    = {mtvec_out[31:2], 2'b00};
                next_state     = IDLE;
            end
            MRET: begin
                csr_addr       = MEPC_ADDR;
                is_mret        = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_out[31:1], 1'b0};
                next_state     = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
